alu_arbiter: RTL and testbench

//   Shares one combinational ALU instance between two requesters, e.g. the execute stage and an address/branch helper.

---
 rtl/alu_arbiter.sv | 103 ++++++++++
 tb/tb_alu_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-port valid/ready front end that time-shares one external combinational ALU.
// A single issue register holds the in-flight op; its result is returned to the owning port.
module alu_arbiter #(
  parameter int BIT_SIZE = 32,
  parameter int CNT_W    = 16,
  parameter bit RR_EN    = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [4:0]          req0_op,
  input  logic [BIT_SIZE-1:0] req0_src1,
  input  logic [BIT_SIZE-1:0] req0_src2,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [4:0]          req1_op,
  input  logic [BIT_SIZE-1:0] req1_src1,
  input  logic [BIT_SIZE-1:0] req1_src2,
  output logic                rsp0_valid,
  input  logic                rsp0_ready,
  output logic                rsp1_valid,
  input  logic                rsp1_ready,
  output logic [BIT_SIZE-1:0] rsp_result,
  output logic                rsp_br,
  output logic [4:0]          alu_op,
  output logic [BIT_SIZE-1:0] alu_src1,
  output logic [BIT_SIZE-1:0] alu_src2,
  input  logic [BIT_SIZE-1:0] alu_result,
  input  logic                alu_br,
  output logic [CNT_W-1:0]    grant_cnt0,
  output logic [CNT_W-1:0]    grant_cnt1
);

  logic                s_valid;
  logic                s_owner;
  logic [4:0]          s_op;
  logic [BIT_SIZE-1:0] s_src1;
  logic [BIT_SIZE-1:0] s_src2;
  logic                last_grant;
  logic                rsp_fire;
  logic                free;
  logic                grant;
  logic                accept;

  assign rsp0_valid = s_valid & ~s_owner;
  assign rsp1_valid = s_valid & s_owner;
  assign rsp_fire   = s_owner ? (rsp1_valid & rsp1_ready) : (rsp0_valid & rsp0_ready);
  // The slot is reusable in the same cycle its response is consumed.
  assign free       = rst_n & (~s_valid | rsp_fire);

  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid)
      grant = RR_EN ? ~last_grant : 1'b0;
    else
      grant = req1_valid;
  end

  assign req0_ready = free & ~grant & req0_valid;
  assign req1_ready = free & grant & req1_valid;
  assign accept     = req0_ready | req1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_valid    <= 1'b0;
      s_owner    <= 1'b0;
      s_op       <= '0;
      s_src1     <= '0;
      s_src2     <= '0;
      last_grant <= 1'b1;
    end else if (accept) begin
      s_valid    <= 1'b1;
      s_owner    <= grant;
      s_op       <= grant ? req1_op   : req0_op;
      s_src1     <= grant ? req1_src1 : req0_src1;
      s_src2     <= grant ? req1_src2 : req0_src2;
      last_grant <= grant;
    end else if (rsp_fire) begin
      s_valid    <= 1'b0;
    end
  end

  // Saturating acceptance counters, one per port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_ready && grant_cnt0 != '1)
        grant_cnt0 <= grant_cnt0 + CNT_W'(1);
      if (req1_ready && grant_cnt1 != '1)
        grant_cnt1 <= grant_cnt1 + CNT_W'(1);
    end
  end

  assign alu_op     = s_valid ? s_op   : '0;
  assign alu_src1   = s_valid ? s_src1 : '0;
  assign alu_src2   = s_valid ? s_src2 : '0;
  assign rsp_result = s_valid ? alu_result : '0;
  assign rsp_br     = s_valid & alu_br;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural ALU feeds the DUT, the driver queues
// expected responses at accept time and a monitor retires them as responses are consumed.
module tb_alu_arbiter;

  typedef struct {
    bit          port;
    logic [31:0] res;
    bit          br;
  } sb_entry_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
  logic [4:0]  req0_op = '0, req1_op = '0;
  logic [31:0] req0_src1 = '0, req0_src2 = '0, req1_src1 = '0, req1_src2 = '0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_br, alu_br;
  logic [31:0] rsp_result, alu_src1, alu_src2, alu_result;
  logic [4:0]  alu_op;
  logic [15:0] grant_cnt0, grant_cnt1;
  logic [32:0] alu_out;

  logic        b_req0_valid = 0, b_req1_valid = 0;
  logic        b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid, b_rsp_br, b_alu_br;
  logic [31:0] b_rsp_result, b_alu_src1, b_alu_src2, b_alu_result;
  logic [4:0]  b_alu_op;
  logic [3:0]  b_grant_cnt0, b_grant_cnt1;
  logic [32:0] b_alu_out;

  int vectors = 0;
  int miscompares = 0;
  sb_entry_t sb[$];

  always #5 clk = ~clk;

  // Reference ALU: 1 ADD, 2 SUB, 11 BEQ, 19 JALR; anything else yields zero.
  function automatic logic [32:0] aluModel(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'd1:    return {1'b0, a + b};
      5'd2:    return {1'b0, a - b};
      5'd11:   return {a == b, 32'd0};
      5'd19:   return {1'b1, a + b};
      default: return 33'd0;
    endcase
  endfunction

  assign alu_out      = aluModel(alu_op, alu_src1, alu_src2);
  assign alu_result   = alu_out[31:0];
  assign alu_br       = alu_out[32];
  assign b_alu_out    = aluModel(b_alu_op, b_alu_src1, b_alu_src2);
  assign b_alu_result = b_alu_out[31:0];
  assign b_alu_br     = b_alu_out[32];

  alu_arbiter #(.BIT_SIZE(32), .CNT_W(16), .RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_src1(req0_src1), .req0_src2(req0_src2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_src1(req1_src1), .req1_src2(req1_src2),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_br(rsp_br),
    .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_result(alu_result), .alu_br(alu_br),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  alu_arbiter #(.BIT_SIZE(32), .CNT_W(4), .RR_EN(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_op(5'd1),
    .req0_src1(32'd1), .req0_src2(32'd1),
    .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_op(5'd1),
    .req1_src1(32'd2), .req1_src2(32'd2),
    .rsp0_valid(b_rsp0_valid), .rsp0_ready(1'b1),
    .rsp1_valid(b_rsp1_valid), .rsp1_ready(1'b1),
    .rsp_result(b_rsp_result), .rsp_br(b_rsp_br),
    .alu_op(b_alu_op), .alu_src1(b_alu_src1), .alu_src2(b_alu_src2),
    .alu_result(b_alu_result), .alu_br(b_alu_br),
    .grant_cnt0(b_grant_cnt0), .grant_cnt1(b_grant_cnt1)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void push(input bit port, input logic [31:0] res, input bit br);
    sb_entry_t e;
    e.port = port;
    e.res  = res;
    e.br   = br;
    sb.push_back(e);
  endfunction

  // Presents one request on a port (called at a falling edge) and waits for it to be accepted.
  task automatic applyStimulus(input bit port, input logic [4:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_res,
                               input bit exp_br, input bit expect_rsp);
    bit done = 0;
    if (port) begin req1_valid = 1; req1_op = op; req1_src1 = a; req1_src2 = b; end
    else      begin req0_valid = 1; req0_op = op; req0_src1 = a; req0_src2 = b; end
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if ((port ? req1_ready : req0_ready) === 1'b1) begin
        if (expect_rsp) push(port, exp_res, exp_br);
        done = 1;
      end
      @(negedge clk);
    end
    if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
    if (port) req1_valid = 0; else req0_valid = 0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  // Monitor: retires one scoreboard entry each time a response is consumed.
  initial begin
    sb_entry_t e;
    bit        port;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready))) begin
        port = rsp1_valid;
        if (sb.size() == 0) begin
          checkOutput("sb_unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("rsp_port", {31'd0, port}, {31'd0, e.port});
          checkOutput("rsp_result", rsp_result, e.res);
          checkOutput("rsp_br", {31'd0, rsp_br}, {31'd0, e.br});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n0 = 0, n1 = 0, acc = 0, b_acc = 0, b_p1 = 0;

    // Reset state, with a request already waiting.
    req0_valid = 1; req0_op = 5'd1;
    #2;
    checkOutput("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    checkOutput("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    checkOutput("rst_alu_op", {27'd0, alu_op}, 32'd0);
    checkOutput("rst_rsp_result", rsp_result, 32'd0);
    checkOutput("rst_grant_cnt0", {16'd0, grant_cnt0}, 32'd0);
    req0_valid = 0;
    @(negedge clk);
    rst_n = 1;
    rsp0_ready = 1; rsp1_ready = 1;

    // T1: single ADD on port 0.
    applyStimulus(0, 5'd1, 32'd5, 32'd7, 32'd12, 1'b0, 1'b1);
    #2;
    checkOutput("t1_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    checkOutput("t1_alu_op", {27'd0, alu_op}, 32'd1);
    @(negedge clk); @(negedge clk);
    checkOutput("t1_grant_cnt0", {16'd0, grant_cnt0}, 32'd1);

    // T2: both ports streaming ADDs, round-robin from a fresh reset.
    doReset();
    req0_valid = 1; req1_valid = 1; req0_op = 5'd1; req1_op = 5'd1;
    for (int cyc = 0; cyc < 20 && acc < 8; cyc++) begin
      req0_src1 = n0;       req0_src2 = 32'd3;
      req1_src1 = 100 + n1; req1_src2 = 32'd3;
      #1;
      checkOutput("t2_one_ready", {31'd0, req0_ready ^ req1_ready}, 32'd1);
      checkOutput("t2_grant_port", {31'd0, req1_ready}, acc % 2);
      if (req0_ready === 1'b1) begin push(0, n0 + 3, 0); n0++; acc++; end
      else if (req1_ready === 1'b1) begin push(1, 103 + n1, 0); n1++; acc++; end
      @(negedge clk);
    end
    req0_valid = 0; req1_valid = 0;
    @(negedge clk); @(negedge clk);
    checkOutput("t2_grant_cnt0", {16'd0, grant_cnt0}, 32'd4);
    checkOutput("t2_grant_cnt1", {16'd0, grant_cnt1}, 32'd4);

    // T3: SUB held under backpressure while port 1 waits.
    rsp0_ready = 0;
    applyStimulus(0, 5'd2, 32'd9, 32'd3, 32'd6, 1'b0, 1'b1);
    req1_valid = 1; req1_op = 5'd1; req1_src1 = 32'd1; req1_src2 = 32'd1;
    for (int i = 0; i < 3; i++) begin
      #2;
      checkOutput("t3_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
      checkOutput("t3_rsp_result", rsp_result, 32'd6);
      checkOutput("t3_req0_ready", {31'd0, req0_ready}, 32'd0);
      checkOutput("t3_req1_ready", {31'd0, req1_ready}, 32'd0);
      @(negedge clk);
    end
    rsp0_ready = 1;
    #1;
    checkOutput("t3_req1_same_edge", {31'd0, req1_ready}, 32'd1);
    if (req1_ready === 1'b1) push(1, 32'd2, 0);
    @(negedge clk);
    req1_valid = 0;
    @(negedge clk);

    // T4: branch-style ops on port 1.
    applyStimulus(1, 5'd11, 32'hA, 32'hA, 32'd0, 1'b1, 1'b1);
    applyStimulus(1, 5'd19, 32'h100, 32'd4, 32'h104, 1'b1, 1'b1);
    @(negedge clk); @(negedge clk);

    // T5: reset with an op in flight drops it; port 0 wins the first tie afterwards.
    rsp0_ready = 0;
    applyStimulus(0, 5'd1, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0);
    #2;
    rst_n = 0;
    #1;
    checkOutput("t5_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    checkOutput("t5_grant_cnt0", {16'd0, grant_cnt0}, 32'd0);
    checkOutput("t5_alu_op", {27'd0, alu_op}, 32'd0);
    @(negedge clk);
    rst_n = 1; rsp0_ready = 1;
    req0_valid = 1; req0_op = 5'd1; req0_src1 = 32'd1; req0_src2 = 32'd1;
    req1_valid = 1; req1_op = 5'd1; req1_src1 = 32'd2; req1_src2 = 32'd2;
    #1;
    checkOutput("t5_first_req0", {31'd0, req0_ready}, 32'd1);
    checkOutput("t5_first_req1", {31'd0, req1_ready}, 32'd0);
    if (req0_ready === 1'b1) push(0, 32'd2, 0);
    @(negedge clk);
    req0_valid = 0;
    #1;
    checkOutput("t5_then_req1", {31'd0, req1_ready}, 32'd1);
    if (req1_ready === 1'b1) push(1, 32'd4, 0);
    @(negedge clk);
    req1_valid = 0;
    @(negedge clk); @(negedge clk);

    // T6: fixed priority, 4-bit counters saturate.
    b_req0_valid = 1; b_req1_valid = 1;
    for (int cyc = 0; cyc < 40 && b_acc < 17; cyc++) begin
      #1;
      if (b_req0_ready === 1'b1) b_acc++;
      if (b_req1_ready === 1'b1) b_p1++;
      @(negedge clk);
    end
    b_req0_valid = 0; b_req1_valid = 0;
    @(negedge clk);
    checkOutput("t6_accepts", b_acc, 32'd17);
    checkOutput("t6_port1_grants", b_p1, 32'd0);
    checkOutput("t6_grant_cnt0", {28'd0, b_grant_cnt0}, 32'd15);
    checkOutput("t6_grant_cnt1", {28'd0, b_grant_cnt1}, 32'd0);

    @(negedge clk); @(negedge clk);
    checkOutput("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
